// File: rtl/softmax_frame_serializer_if.sv
// softmax_frame_serializer_if: frame-in / beat-out bundle for the softmax frame serializer.
// Ports: in_data/in_valid/in_ready carry one whole NUM_CH-word frame (channel 0 at the LSBs);
//        out_data/out_idx/out_last/out_valid/out_ready carry one channel word per beat.
interface softmax_frame_serializer_if #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 10,
  parameter int IDX_W      = $clog2(NUM_CH + 1)
);
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [IDX_W-1:0]             out_idx;
  logic                         out_last;
  logic                         out_valid;
  logic                         out_ready;

  // master: the frame producer and beat consumer around the serializer
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_last, out_valid
  );

  // slave: the serializer itself
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_last, out_valid
  );
endinterface

// File: rtl/softmax_frame_serializer.sv
// Purpose     : capture one frame of NUM_CH words, stream it out one word per beat with 1-based idx and last flag.
// Latency     : first beat valid the cycle after frame capture; NUM_CH+1 cycles minimum frame period.
// Backpressure: out_ready low holds every output; in_ready low for the whole streaming phase.
// Ports: clk (rising edge), rst_n (synchronous, active-low), sif (slave modport of softmax_frame_serializer_if).
module softmax_frame_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 10,
  parameter int IDX_W      = $clog2(NUM_CH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  softmax_frame_serializer_if.slave sif
);
  localparam int               PTR_W    = $clog2(NUM_CH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CH - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] bank [NUM_CH];
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  last_q;
  logic                  valid_q;
  logic                  load;

  assign load    = (state == IDLE) && sif.in_valid;
  assign ptr_nxt = ptr + PTR_W'(1);

  // Frame storage carries no reset: every word is rewritten before it is ever read.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NUM_CH; k++) begin
        bank[k] <= sif.in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sif.in_valid) begin
            // Channel 0 comes straight from the input so it is presented the very next cycle.
            state   <= STREAM;
            ptr     <= '0;
            data_q  <= sif.in_data[DATA_WIDTH-1:0];
            idx_q   <= IDX_W'(1);
            last_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        STREAM: begin
          if (sif.out_ready) begin
            if (ptr == LAST_PTR) begin
              state   <= IDLE;
              ptr     <= '0;
              data_q  <= '0;
              idx_q   <= '0;
              last_q  <= 1'b0;
              valid_q <= 1'b0;
            end else begin
              // Next beat is ptr+1, whose 1-based index is ptr+2.
              ptr    <= ptr_nxt;
              data_q <= bank[ptr_nxt];
              idx_q  <= IDX_W'(ptr) + IDX_W'(2);
              last_q <= (ptr_nxt == LAST_PTR);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sif.in_ready  = (state == IDLE);
  assign sif.out_data  = data_q;
  assign sif.out_idx   = idx_q;
  assign sif.out_last  = last_q;
  assign sif.out_valid = valid_q;
endmodule

// File: tb/tb_softmax_frame_serializer.sv
// tb_softmax_frame_serializer: directed bench for the frame serializer.
// Ports: none; drives a default 10x24 instance plus 2x8 and 16x32 instances sharing clk/rst_n.
module tb_softmax_frame_serializer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   cyc_a;
  int   cyc_b;
  int   exp_k;
  logic rdy;
  logic [15:0] pat;
  logic [7:0]  f1 [2];
  logic [31:0] f2 [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  softmax_frame_serializer_if #(.DATA_WIDTH(24), .NUM_CH(10)) if0 ();
  softmax_frame_serializer_if #(.DATA_WIDTH(8),  .NUM_CH(2))  if1 ();
  softmax_frame_serializer_if #(.DATA_WIDTH(32), .NUM_CH(16)) if2 ();

  softmax_frame_serializer #(.DATA_WIDTH(24), .NUM_CH(10)) dut0 (.clk(clk), .rst_n(rst_n), .sif(if0));
  softmax_frame_serializer #(.DATA_WIDTH(8),  .NUM_CH(2))  dut1 (.clk(clk), .rst_n(rst_n), .sif(if1));
  softmax_frame_serializer #(.DATA_WIDTH(32), .NUM_CH(16)) dut2 (.clk(clk), .rst_n(rst_n), .sif(if2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it; all sampling and driving happens here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [23:0] base);
    for (int k = 0; k < 10; k++) begin
      if0.in_data[k*24 +: 24] = base + 24'(k);
    end
  endtask

  task automatic expect_idle0(input string tag);
    chk({tag, "_valid"}, 64'(if0.out_valid), 64'd0);
    chk({tag, "_idx"},   64'(if0.out_idx),   64'd0);
    chk({tag, "_data"},  64'(if0.out_data),  64'd0);
    chk({tag, "_last"},  64'(if0.out_last),  64'd0);
    chk({tag, "_inrdy"}, 64'(if0.in_ready),  64'd1);
  endtask

  // Called right after the capture edge with out_ready held high.
  task automatic expect_frame0(input logic [23:0] base, input string tag);
    for (int k = 0; k < 10; k++) begin
      chk({tag, "_valid"}, 64'(if0.out_valid), 64'd1);
      chk({tag, "_idx"},   64'(if0.out_idx),   64'(k + 1));
      chk({tag, "_data"},  64'(if0.out_data),  64'(base + 24'(k)));
      chk({tag, "_last"},  64'(if0.out_last),  64'(k == 9));
      chk({tag, "_inrdy"}, 64'(if0.in_ready),  64'd0);
      tick();
    end
    expect_idle0({tag, "_end"});
  endtask

  initial begin
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0;

    // Reset held 3 cycles, then idle with in_valid low.
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_idle0("rst");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_idle0("idle");
    end
    chk("idle_n2_valid", 64'(if1.out_valid), 64'd0);
    chk("idle_n16_idx",  64'(if2.out_idx),   64'd0);

    // Full frame, no stall.
    load0(24'h000100);
    if0.in_valid  = 1'b1;
    if0.out_ready = 1'b1;
    tick();
    if0.in_valid = 1'b0;
    expect_frame0(24'h000100, "full");

    // Backpressure: fixed opening pattern 1,0,0,1,0,1,... then random.
    pat = 16'b1011_0010_0010_1001;
    load0(24'h000200);
    if0.in_valid  = 1'b1;
    if0.out_ready = 1'b0;
    tick();
    if0.in_valid = 1'b0;
    exp_k = 0;
    for (int c = 0; c < 200 && exp_k < 10; c++) begin
      rdy = (c < 16) ? pat[c] : 1'($urandom_range(0, 1));
      chk("bp_valid", 64'(if0.out_valid), 64'd1);
      chk("bp_idx",   64'(if0.out_idx),   64'(exp_k + 1));
      chk("bp_data",  64'(if0.out_data),  64'(24'h000200 + 24'(exp_k)));
      chk("bp_last",  64'(if0.out_last),  64'(exp_k == 9));
      if0.out_ready = rdy;
      tick();
      if (rdy) exp_k++;
    end
    chk("bp_done", 64'(exp_k), 64'd10);
    expect_idle0("bp_end");
    if0.out_ready = 1'b1;

    // Back-to-back: in_valid stays high, B offered right after A is taken.
    load0(24'h000A00);
    if0.in_valid = 1'b1;
    tick();
    cyc_a = cyc;
    load0(24'h000B00);
    for (int k = 0; k < 10; k++) begin
      chk("b2b_a_idx",   64'(if0.out_idx),  64'(k + 1));
      chk("b2b_a_data",  64'(if0.out_data), 64'(24'h000A00 + 24'(k)));
      chk("b2b_a_inrdy", 64'(if0.in_ready), 64'd0);
      tick();
    end
    expect_idle0("b2b_gap");
    tick();
    cyc_b = cyc;
    if0.in_valid = 1'b0;
    chk("b2b_dist", 64'(cyc_b - cyc_a), 64'd11);
    expect_frame0(24'h000B00, "b2b_b");

    // Reset while idx 4 is presented.
    load0(24'h000C00);
    if0.in_valid = 1'b1;
    tick();
    if0.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_pre_idx", 64'(if0.out_idx), 64'd4);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(if0.out_valid), 64'd0);
    chk("mid_rst_idx",   64'(if0.out_idx),   64'd0);
    chk("mid_rst_inrdy", 64'(if0.in_ready),  64'd1);
    rst_n = 1'b1;
    tick();
    expect_idle0("mid_post");
    load0(24'h000D00);
    if0.in_valid = 1'b1;
    tick();
    if0.in_valid = 1'b0;
    expect_frame0(24'h000D00, "mid_new");

    // Parameter sweep: 2x8 and 16x32 with random frames, run side by side.
    for (int k = 0; k < 2; k++) begin
      f1[k] = 8'($urandom);
      if1.in_data[k*8 +: 8] = f1[k];
    end
    for (int k = 0; k < 16; k++) begin
      f2[k] = 32'($urandom);
      if2.in_data[k*32 +: 32] = f2[k];
    end
    if1.in_valid = 1'b1; if1.out_ready = 1'b1;
    if2.in_valid = 1'b1; if2.out_ready = 1'b1;
    tick();
    if1.in_valid = 1'b0;
    if2.in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k < 2) begin
        chk("n2_valid", 64'(if1.out_valid), 64'd1);
        chk("n2_idx",   64'(if1.out_idx),   64'(k + 1));
        chk("n2_data",  64'(if1.out_data),  64'(f1[k]));
        chk("n2_last",  64'(if1.out_last),  64'(k == 1));
      end else if (k == 2) begin
        chk("n2_end_valid", 64'(if1.out_valid), 64'd0);
        chk("n2_end_idx",   64'(if1.out_idx),   64'd0);
        chk("n2_end_inrdy", 64'(if1.in_ready),  64'd1);
      end
      chk("n16_valid", 64'(if2.out_valid), 64'd1);
      chk("n16_idx",   64'(if2.out_idx),   64'(k + 1));
      chk("n16_data",  64'(if2.out_data),  64'(f2[k]));
      chk("n16_last",  64'(if2.out_last),  64'(k == 15));
      tick();
    end
    chk("n16_end_valid", 64'(if2.out_valid), 64'd0);
    chk("n16_end_idx",   64'(if2.out_idx),   64'd0);
    chk("n16_end_inrdy", 64'(if2.in_ready),  64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
